karatsuba_seq_divider: RTL and testbench

//   Iterative unsigned radix-2 restoring divider: the inverse datapath to the karatsuba multiplier tree.

---
 rtl/karatsuba_pkg.sv | 16 +
 rtl/karatsuba_div_step.sv | 29 ++
 rtl/karatsuba_seq_divider.sv | 128 ++++++++++++
 tb/tb_karatsuba_seq_divider.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared definitions for the karatsuba sequential arithmetic blocks:
// FSM state encodings and the iteration-counter width helper.
package karatsuba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // One extra bit so the counter can represent N itself without wrapping.
  function automatic int DIV_CNT_W(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/karatsuba_div_step.sv
// One combinational radix-2 restoring division step: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, restore on borrow.
module karatsuba_div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   p_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] d_in,
  output logic [N:0]   p_out,
  output logic [N-1:0] q_out
);

  logic [N:0] shifted;
  logic [N:0] trial;

  always_comb begin
    shifted = {p_in[N-1:0], q_in[N-1]};
    trial   = shifted - {1'b0, d_in};
    // Top bit of the trial difference is the borrow: the divisor did not fit.
    if (trial[N]) begin
      p_out = shifted;
      q_out = {q_in[N-2:0], 1'b0};
    end else begin
      p_out = trial;
      q_out = {q_in[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/karatsuba_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro KARATSUBA_DIV_ZERO_EN: short-circuit v==0 straight to DONE with div_err=1.
module karatsuba_seq_divider
  import karatsuba_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] u,
  input  logic [N-1:0] v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div_err
);

  localparam int CW = DIV_CNT_W(N);

  div_state_e  state_q, state_d;
  logic [N:0]  p_q, p_d;
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N:0]   p_step;
  logic [N-1:0] quo_step;
  logic         accept;
  logic         skip_busy;

  assign accept = in_valid & in_ready;

`ifdef KARATSUBA_DIV_ZERO_EN
  logic err_q, err_d;
  assign skip_busy = (v == '0);
  assign div_err   = err_q;
`else
  assign skip_busy = 1'b0;
  assign div_err   = 1'b0;
`endif

  karatsuba_div_step #(.N(N)) u_step (
    .p_in  (p_q),
    .q_in  (quo_q),
    .d_in  (d_q),
    .p_out (p_step),
    .q_out (quo_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = skip_busy ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt_q == CW'(N - 1)) state_d = ST_DONE;
      ST_DONE: if (out_valid && out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    p_d   = p_q;
    quo_d = quo_q;
    d_d   = d_q;
    cnt_d = cnt_q;
`ifdef KARATSUBA_DIV_ZERO_EN
    err_d = err_q;
`endif
    if (state_q == ST_IDLE && accept) begin
      d_d   = v;
      cnt_d = '0;
      // A skipped divide-by-zero lands directly on the natural restoring result.
      if (skip_busy) begin
        p_d   = {1'b0, u};
        quo_d = '1;
      end else begin
        p_d   = '0;
        quo_d = u;
      end
`ifdef KARATSUBA_DIV_ZERO_EN
      err_d = skip_busy;
`endif
    end else if (state_q == ST_BUSY) begin
      p_d   = p_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      quo_q <= '0;
      d_q   <= '0;
      cnt_q <= '0;
`ifdef KARATSUBA_DIV_ZERO_EN
      err_q <= 1'b0;
`endif
    end else begin
      p_q   <= p_d;
      quo_q <= quo_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
`ifdef KARATSUBA_DIV_ZERO_EN
      err_q <= err_d;
`endif
    end
  end

  assign q = quo_q;
  assign r = p_q[N-1:0];

endmodule

// File: tb/tb_karatsuba_seq_divider.sv
// Scoreboard bench for karatsuba_seq_divider (N=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every output handshake.
module tb_karatsuba_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] u = '0;
  logic [N-1:0] v = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_err;

  karatsuba_seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
`ifdef KARATSUBA_DIV_ZERO_EN
      e.err = 1'b1;
`else
      e.err = 1'b0;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef KARATSUBA_DIV_ZERO_EN
    if (b == '0) return 0;
`endif
    return N;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when both are high here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: got q=%0d r=%0d err=%0d with nothing expected", q, r, div_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (q !== e.q || r !== e.r || div_err !== e.err) begin
          bad++;
          $display("FAIL result: got q=%0d r=%0d err=%0d expected q=%0d r=%0d err=%0d",
                   q, r, div_err, e.q, e.r, e.err);
        end else begin
          $display("result q=%0d r=%0d err=%0d ok", q, r, div_err);
        end
      end
    end
  end

  // Caller sits #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    check("wait_in_ready", in_ready, 1);
    in_valid = 1'b1;
    u = a;
    v = b;
    sb.push_back(model(a, b));
    $display("issue u=%0d v=%0d", a, b);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat, input string name);
    int k;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check(name, k, lat);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    issue(a, b, 1'b0);
    wait_result(exp_lat(b), "latency");
    @(posedge clk); #1;
    check("post_done_in_ready", in_ready, 1);
    check("post_done_out_valid", out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    check("reset_div_err", div_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Main case and corners
    run_op(8'd200, 8'd7);
    run_op(8'd255, 8'd1);
    run_op(8'd5, 8'd9);
    run_op(8'd0, 8'd3);
    run_op(8'd13, 8'd13);
    run_op(8'd77, 8'd0);
    run_op(8'd255, 8'd255);
    run_op(8'd254, 8'd255);
    run_op(8'd255, 8'd2);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(8'd150, 8'd11, 1'b0);
    wait_result(N, "bp_latency");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_q", q, 13);
      check("bp_r", r, 7);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Reset during step 4 drops the operation
    issue(8'd100, 8'd3, 1'b0);
    void'(sb.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    run_op(8'd100, 8'd3);

    // in_valid held high with changing operands must not re-accept or corrupt
    issue(8'd100, 8'd7, 1'b1);
    u = 8'd250;
    v = 8'd2;
    wait_result(N, "hold_latency");
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_in_ready", in_ready, 1);
    check("hold_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("hold_no_reaccept", in_ready, 1);

    // Random pairs against the reference model, v=0 sprinkled in
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom_range(0, 255));
      b = (i % 16 == 5) ? '0 : N'($urandom_range(0, 255));
      run_op(a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
